// File: rtl/memory_access_unit_way0_pkg.sv
// Shared opcodes, funct3 size codes and FSM state encoding for the way0 memory-access stage.
package memory_access_unit_way0_pkg;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    function automatic logic [3:0] access_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            SIZE_B:  return 4'd1;
            SIZE_H:  return 4'd2;
            SIZE_W:  return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_unit_way0_mem_align.sv
// Byte-lane alignment for way0: misalign detect, store strobes/data placement, load extraction/extension.
module mem_align_way0
    import memory_access_unit_way0_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [2:0]      addr,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] read_data,
    output logic            misalign,
    output logic [7:0]      write_mask,
    output logic [XLEN-1:0] write_data,
    output logic [XLEN-1:0] load_data
);

    logic [3:0]      nbytes;
    logic [5:0]      lane_shift;
    logic [7:0]      size_mask;
    logic [XLEN-1:0] data_mask;
    logic [XLEN-1:0] lane;

    function automatic logic [XLEN-1:0] extend_load(input logic [2:0] f3, input logic [XLEN-1:0] raw);
        case (f3)
            F3_B:    return {{(XLEN-8){raw[7]}}, raw[7:0]};
            F3_H:    return {{(XLEN-16){raw[15]}}, raw[15:0]};
            F3_W:    return {{(XLEN-32){raw[31]}}, raw[31:0]};
            F3_BU:   return {{(XLEN-8){1'b0}}, raw[7:0]};
            F3_HU:   return {{(XLEN-16){1'b0}}, raw[15:0]};
            F3_WU:   return {{(XLEN-32){1'b0}}, raw[31:0]};
            F3_D:    return raw;
            default: return raw;
        endcase
    endfunction

    always_comb begin
        nbytes     = access_bytes(funct3);
        lane_shift = {addr, 3'b000};
        // An access crosses the doubleword when its last byte lands past lane 7.
        misalign   = ({1'b0, addr} + nbytes) > 4'd8;
        case (funct3[1:0])
            SIZE_B:  size_mask = 8'h01;
            SIZE_H:  size_mask = 8'h03;
            SIZE_W:  size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        for (int i = 0; i < XLEN/8; i++) begin
            data_mask[8*i +: 8] = {8{size_mask[i]}};
        end
        write_mask = size_mask << addr;
        write_data = (store_data & data_mask) << lane_shift;
        lane       = read_data >> lane_shift;
        load_data  = extend_load(funct3, lane);
    end

endmodule

// File: rtl/memory_access_unit_way0.sv
// Way0 memory-access stage: D-cache load/store sequencing and a single registered writeback slot.
// Optional MEM_TESTPORT_EN adds instAddr/inst trace ports carried alongside the slot.
module memory_access_unit_way0
    import memory_access_unit_way0_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [6:0]        opCode_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   aluResult_i,
    input  logic [XLEN-1:0]   storeData_i,
    input  logic [4:0]        rdAddr_i,
    input  logic              rdWriteEnable_i,
    input  logic [1:0]        way0_pID_i,
    output logic              request_o,
    output logic              writeEnable_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [XLEN-1:0]   writeData_o,
    output logic [7:0]        writeMask_o,
    input  logic              dataOk_i,
    input  logic [XLEN-1:0]   readData_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [4:0]        rdAddr_o,
    output logic              rdWriteEnable_o,
    output logic [XLEN-1:0]   rdWriteData_o,
    output logic [1:0]        way0_pID_o,
`ifdef MEM_TESTPORT_EN
    input  logic [31:0]       instAddr_i,
    input  logic [31:0]       inst_i,
    output logic [31:0]       instAddr_o,
    output logic [31:0]       inst_o,
`endif
    output logic              misalign_o
);

    state_t          state;
    logic            transfer;
    logic            is_load;
    logic            is_store;
    logic            is_mem;
    logic            go_access;
    logic            fill_now;
    logic            mem_done;

    logic [2:0]      funct3_p1;
    logic [4:0]      rd_addr_p1;
    logic            rd_we_p1;
    logic [1:0]      pid_p1;
    logic            is_load_p1;

    logic [2:0]      align_funct3;
    logic [2:0]      align_addr;
    logic            align_misalign;
    logic [7:0]      align_mask;
    logic [XLEN-1:0] align_wdata;
    logic [XLEN-1:0] align_load;

    assign ready_o   = (state == IDLE) || ((state == HOLD) && ready_i);
    assign transfer  = valid_i && ready_o;
    assign is_load   = (opCode_i == OPCODE_LOAD);
    assign is_store  = (opCode_i == OPCODE_STORE);
    assign is_mem    = is_load || is_store;
    assign go_access = transfer && is_mem && !align_misalign;
    assign fill_now  = transfer && !go_access;
    assign mem_done  = (state == ACCESS) && request_o && dataOk_i;

    // No transfer can occur in ACCESS, so the aligner is shared between issue and completion.
    assign align_funct3 = (state == ACCESS) ? funct3_p1   : funct3_i;
    assign align_addr   = (state == ACCESS) ? addr_o[2:0] : aluResult_i[2:0];

    mem_align_way0 #(.XLEN(XLEN)) u_align (
        .funct3     (align_funct3),
        .addr       (align_addr),
        .store_data (storeData_i),
        .read_data  (readData_i),
        .misalign   (align_misalign),
        .write_mask (align_mask),
        .write_data (align_wdata),
        .load_data  (align_load)
    );

    // Stage p1: writeback metadata parked while the D-cache access is in flight
    always_ff @(posedge clk) begin
        if (transfer) begin
            funct3_p1  <= funct3_i;
            rd_addr_p1 <= rdAddr_i;
            rd_we_p1   <= rdWriteEnable_i;
            pid_p1     <= way0_pID_i;
            is_load_p1 <= is_load;
        end
    end

    // Stage p2: request registers and writeback slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            request_o       <= 1'b0;
            writeEnable_o   <= 1'b0;
            addr_o          <= '0;
            writeData_o     <= '0;
            writeMask_o     <= '0;
            valid_o         <= 1'b0;
            rdAddr_o        <= '0;
            rdWriteEnable_o <= 1'b0;
            rdWriteData_o   <= '0;
            way0_pID_o      <= '0;
            misalign_o      <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (go_access) begin
                        state         <= ACCESS;
                        request_o     <= 1'b1;
                        writeEnable_o <= is_store;
                        addr_o        <= aluResult_i[ADDR_W-1:0];
                        writeData_o   <= align_wdata;
                        writeMask_o   <= align_mask;
                        valid_o       <= 1'b0;
                    end else if (fill_now) begin
                        state           <= HOLD;
                        valid_o         <= 1'b1;
                        rdAddr_o        <= rdAddr_i;
                        rdWriteEnable_o <= is_mem ? 1'b0 : rdWriteEnable_i;
                        rdWriteData_o   <= is_mem ? '0 : aluResult_i;
                        way0_pID_o      <= way0_pID_i;
                        misalign_o      <= is_mem;
                    end else if ((state == HOLD) && ready_i) begin
                        state   <= IDLE;
                        valid_o <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (mem_done) begin
                        state           <= HOLD;
                        request_o       <= 1'b0;
                        valid_o         <= 1'b1;
                        rdAddr_o        <= rd_addr_p1;
                        rdWriteEnable_o <= is_load_p1 && rd_we_p1;
                        rdWriteData_o   <= is_load_p1 ? align_load : '0;
                        way0_pID_o      <= pid_p1;
                        misalign_o      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    request_o <= 1'b0;
                    valid_o   <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_TESTPORT_EN
    logic [31:0] inst_addr_p1;
    logic [31:0] inst_p1;

    always_ff @(posedge clk) begin
        if (transfer) begin
            inst_addr_p1 <= instAddr_i;
            inst_p1      <= inst_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instAddr_o <= '0;
            inst_o     <= '0;
        end else if (fill_now) begin
            instAddr_o <= instAddr_i;
            inst_o     <= inst_i;
        end else if (mem_done) begin
            instAddr_o <= inst_addr_p1;
            inst_o     <= inst_p1;
        end
    end
`endif

endmodule

// File: tb/tb_memory_access_unit_way0.sv
// Directed + short random bench for memory_access_unit_way0 with a writeback/request scoreboard.
module tb_memory_access_unit_way0;

    localparam int ADDR_W = 32;
    localparam int XLEN   = 64;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADD   = 7'b0110011;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              valid_i;
    logic              ready_o;
    logic [6:0]        opCode_i;
    logic [2:0]        funct3_i;
    logic [XLEN-1:0]   aluResult_i;
    logic [XLEN-1:0]   storeData_i;
    logic [4:0]        rdAddr_i;
    logic              rdWriteEnable_i;
    logic [1:0]        way0_pID_i;
    logic              request_o;
    logic              writeEnable_o;
    logic [ADDR_W-1:0] addr_o;
    logic [XLEN-1:0]   writeData_o;
    logic [7:0]        writeMask_o;
    logic              dataOk_i;
    logic [XLEN-1:0]   readData_i;
    logic              valid_o;
    logic              ready_i;
    logic [4:0]        rdAddr_o;
    logic              rdWriteEnable_o;
    logic [XLEN-1:0]   rdWriteData_o;
    logic [1:0]        way0_pID_o;
    logic              misalign_o;

    always #5 clk = ~clk;

    memory_access_unit_way0 #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
        .opCode_i(opCode_i), .funct3_i(funct3_i), .aluResult_i(aluResult_i),
        .storeData_i(storeData_i), .rdAddr_i(rdAddr_i), .rdWriteEnable_i(rdWriteEnable_i),
        .way0_pID_i(way0_pID_i), .request_o(request_o), .writeEnable_o(writeEnable_o),
        .addr_o(addr_o), .writeData_o(writeData_o), .writeMask_o(writeMask_o),
        .dataOk_i(dataOk_i), .readData_i(readData_i), .valid_o(valid_o), .ready_i(ready_i),
        .rdAddr_o(rdAddr_o), .rdWriteEnable_o(rdWriteEnable_o), .rdWriteData_o(rdWriteData_o),
        .way0_pID_o(way0_pID_o), .misalign_o(misalign_o)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic [63:0] data;
        logic [1:0]  pid;
        logic        mis;
    } slot_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
    } req_t;

    slot_t slot_q[$];
    req_t  req_q[$];

    int checks = 0;
    int errors = 0;
    int mem_lat = 0;
    int req_cnt = 0;
    bit mem_en = 1'b1;
    bit mem_force = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_mis(input logic [2:0] f3, input logic [2:0] a);
        return (int'(a) + (1 << f3[1:0])) > 8;
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [2:0] a, input logic [63:0] rdata);
        logic [63:0] r;
        int n;
        int ai;
        r  = '0;
        n  = 1 << f3[1:0];
        ai = int'(a);
        for (int i = 0; i < n; i++) begin
            if (ai + i < 8) r[8*i +: 8] = rdata[8*(ai+i) +: 8];
        end
        if (!f3[2] && n < 8 && r[8*n-1]) begin
            for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
        end
        return r;
    endfunction

    function automatic void model_store(input logic [2:0] f3, input logic [2:0] a, input logic [63:0] sd,
                                        output logic [7:0] m, output logic [63:0] d);
        int n;
        int ai;
        m  = '0;
        d  = '0;
        n  = 1 << f3[1:0];
        ai = int'(a);
        for (int i = 0; i < n; i++) begin
            if (ai + i < 8) begin
                m[ai+i]           = 1'b1;
                d[8*(ai+i) +: 8]  = sd[8*i +: 8];
            end
        end
    endfunction

    // D-cache model: checks the request against the scoreboard every cycle it is held
    always @(negedge clk) begin
        if (request_o) begin
            chk("req_pending", req_q.size() != 0, 1);
            if (req_q.size() != 0) begin
                chk("req_addr", addr_o, req_q[0].addr);
                chk("req_we", writeEnable_o, req_q[0].we);
                if (req_q[0].we) begin
                    chk("req_wdata", writeData_o, req_q[0].wdata);
                    chk("req_mask", writeMask_o, req_q[0].mask);
                end
            end
            if (mem_en && req_cnt == mem_lat) begin
                dataOk_i = 1'b1;
                if (req_q.size() != 0) req_q.delete(0);
            end else begin
                dataOk_i = 1'b0;
            end
            req_cnt++;
        end else begin
            dataOk_i = mem_force;
            req_cnt  = 0;
        end
    end

    // Writeback consumer: pops the expected slot on every accepted valid_o
    always @(negedge clk) begin
        if (reset_n && valid_o && ready_i) begin
            chk("slot_pending", slot_q.size() != 0, 1);
            if (slot_q.size() != 0) begin
                chk("slot_rd", rdAddr_o, slot_q[0].rd);
                chk("slot_we", rdWriteEnable_o, slot_q[0].we);
                chk("slot_data", rdWriteData_o, slot_q[0].data);
                chk("slot_pid", way0_pID_o, slot_q[0].pid);
                chk("slot_mis", misalign_o, slot_q[0].mis);
                slot_q.delete(0);
            end
        end
    end

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] alu,
                        input logic [63:0] sd, input logic [4:0] rd, input logic we,
                        input logic [1:0] pid, input logic [63:0] exp_data,
                        input logic [63:0] exp_wdata, input logic [7:0] exp_mask);
        slot_t s;
        req_t  r;
        bit    mem;
        bit    mis;
        int    n;
        mem   = (op == OP_LOAD) || (op == OP_STORE);
        mis   = mem && model_mis(f3, alu[2:0]);
        s.rd  = rd;
        s.pid = pid;
        s.mis = mis;
        if (!mem) begin
            s.we   = we;
            s.data = alu;
        end else if (mis || op == OP_STORE) begin
            s.we   = 1'b0;
            s.data = '0;
        end else begin
            s.we   = we;
            s.data = exp_data;
        end
        if (mem && !mis) begin
            r.we    = (op == OP_STORE);
            r.addr  = alu[31:0];
            r.wdata = exp_wdata;
            r.mask  = exp_mask;
            req_q.push_back(r);
        end
        slot_q.push_back(s);
        opCode_i        = op;
        funct3_i        = f3;
        aluResult_i     = alu;
        storeData_i     = sd;
        rdAddr_i        = rd;
        rdWriteEnable_i = we;
        way0_pID_i      = pid;
        valid_i         = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_o && n < 50);
        chk("accept", ready_o, 1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((slot_q.size() != 0 || req_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", n < 100, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] sd;
        logic [63:0] ed;
        logic [63:0] wd;
        logic [7:0]  m;
        int          sel;
        int          n;

        reset_n = 1'b0;
        valid_i = 1'b0;
        opCode_i = '0;
        funct3_i = '0;
        aluResult_i = '0;
        storeData_i = '0;
        rdAddr_i = '0;
        rdWriteEnable_i = 1'b0;
        way0_pID_i = '0;
        readData_i = '0;
        ready_i = 1'b1;
        dataOk_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_req", request_o, 0);
        chk("rst_we", writeEnable_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_wdata", writeData_o, 0);
        chk("rst_mask", writeMask_o, 0);
        chk("rst_rd", rdAddr_o, 0);
        chk("rst_rdwe", rdWriteEnable_o, 0);
        chk("rst_data", rdWriteData_o, 0);
        chk("rst_pid", way0_pID_o, 0);
        chk("rst_mis", misalign_o, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back pass-through
        opCode_i = OP_ADD;
        funct3_i = 3'b000;
        aluResult_i = 64'h1234;
        rdAddr_i = 5'd5;
        rdWriteEnable_i = 1'b1;
        valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            way0_pID_i = i[1:0];
            slot_q.push_back('{rd: 5'd5, we: 1'b1, data: 64'h1234, pid: i[1:0], mis: 1'b0});
            @(negedge clk);
            chk("b2b_ready", ready_o, 1);
            chk("b2b_valid", valid_o, (i > 0));
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        @(negedge clk);
        chk("b2b_valid_last", valid_o, 1);
        drain();

        // LB / LBU sign and zero extension
        readData_i = 64'h0000_0000_80FF_0000;
        mem_lat = 2;
        send(OP_LOAD, 3'b000, 64'h1003, 64'h0, 5'd10, 1'b1, 2'd1, 64'hFFFF_FFFF_FFFF_FF80, 64'h0, 8'h0);
        drain();
        send(OP_LOAD, 3'b100, 64'h1003, 64'h0, 5'd10, 1'b1, 2'd2, 64'h80, 64'h0, 8'h0);
        drain();

        // SW into upper word
        mem_lat = 1;
        send(OP_STORE, 3'b010, 64'h2004, 64'hDEADBEEF, 5'd4, 1'b1, 2'd2, 64'h0, 64'hDEADBEEF_00000000, 8'hF0);
        drain();

        // Misaligned LD
        send(OP_LOAD, 3'b011, 64'h3004, 64'h0, 5'd11, 1'b1, 2'd3, 64'h0, 64'h0, 8'h0);
        @(negedge clk);
        chk("mis_req", request_o, 0);
        chk("mis_valid", valid_o, 1);
        chk("mis_flag", misalign_o, 1);
        chk("mis_rdwe", rdWriteEnable_o, 0);
        drain();

        // Load completing under writeback backpressure
        ready_i = 1'b0;
        readData_i = 64'h1111_2222_8000_0001;
        mem_lat = 0;
        send(OP_LOAD, 3'b010, 64'h10, 64'h0, 5'd7, 1'b1, 2'd2, 64'hFFFF_FFFF_8000_0001, 64'h0, 8'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_o && n < 20);
        chk("hold_wait", valid_o, 1);
        @(posedge clk);
        #1;
        opCode_i = OP_ADD;
        aluResult_i = 64'h55;
        rdAddr_i = 5'd9;
        rdWriteEnable_i = 1'b1;
        way0_pID_i = 2'd3;
        valid_i = 1'b1;
        slot_q.push_back('{rd: 5'd9, we: 1'b1, data: 64'h55, pid: 2'd3, mis: 1'b0});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_valid", valid_o, 1);
            chk("hold_data", rdWriteData_o, 64'hFFFF_FFFF_8000_0001);
            chk("hold_rd", rdAddr_o, 7);
            chk("hold_pid", way0_pID_o, 2);
            chk("hold_ready", ready_o, 0);
            @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        @(negedge clk);
        chk("hold_release", ready_o, 1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        drain();

        // Reset during ACCESS
        mem_en = 1'b0;
        send(OP_LOAD, 3'b011, 64'h40, 64'h0, 5'd3, 1'b1, 2'd1, 64'h0, 64'h0, 8'h0);
        @(negedge clk);
        chk("rst_acc_req", request_o, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_acc_req_drop", request_o, 0);
        chk("rst_acc_valid", valid_o, 0);
        chk("rst_acc_ready", ready_o, 1);
        slot_q.delete();
        req_q.delete();
        mem_en = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mem_force = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ign_req", request_o, 0);
            chk("rst_ign_valid", valid_o, 0);
            chk("rst_ign_ready", ready_o, 1);
        end
        mem_force = 1'b0;
        @(posedge clk);
        #1;

        // Short random mix of loads, stores and pass-throughs
        for (int k = 0; k < 12; k++) begin
            sel = $urandom_range(0, 2);
            op  = (sel == 0) ? OP_LOAD : ((sel == 1) ? OP_STORE : OP_ADD);
            f3  = (sel == 1) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            a   = {32'h0, $urandom};
            sd  = {$urandom, $urandom};
            readData_i = {$urandom, $urandom};
            mem_lat = $urandom_range(0, 3);
            ed = model_load(f3, a[2:0], readData_i);
            model_store(f3, a[2:0], sd, m, wd);
            send(op, f3, a, sd, 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)), 2'(k), ed, wd, m);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access_unit_way0.md
# memory_access_unit_way0

Way0 memory-access stage, directly downstream of the way0 execute unit. It takes executed instructions over a valid/ready handshake and runs loads and stores against the D-cache over a request/dataOk handshake. It sign- or zero-extends load data and presents a single registered writeback slot to the writeback stage. Non-memory instructions pass through with one cycle of latency and full throughput.

## Interface
Parameters:
- ADDR_W, 32, D-cache byte-address width
- XLEN, 64, datapath width

Ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- valid_i  in  1  execute unit has an instruction
- ready_o  out  1  stage can accept this cycle
- opCode_i  in  7  instruction opcode
- funct3_i  in  3  access size and signedness
- aluResult_i  in  XLEN  effective address (LOAD/STORE) or result (other ops)
- storeData_i  in  XLEN  rs2 data for stores
- rdAddr_i  in  5  destination register
- rdWriteEnable_i  in  1  destination write enable
- way0_pID_i  in  2  pipeline ID tag
- request_o  out  1  D-cache request
- writeEnable_o  out  1  1 = store
- addr_o  out  ADDR_W  byte address, aluResult_i[ADDR_W-1:0]
- writeData_o  out  XLEN  store data, shifted into byte lane addr[2:0]
- writeMask_o  out  8  byte strobes, shifted by addr[2:0]
- dataOk_i  in  1  D-cache completes the access
- readData_i  in  XLEN  aligned 8-byte read doubleword
- valid_o  out  1  writeback slot full
- ready_i  in  1  writeback accepts
- rdAddr_o  out  5  destination register
- rdWriteEnable_o  out  1  destination write enable
- rdWriteData_o  out  XLEN  result
- way0_pID_o  out  2  pipeline ID tag
- misalign_o  out  1  slot holds a misaligned access

## Operation
- Opcodes: LOAD = 7'b0000011, STORE = 7'b0100011. Any other opcode is a pass-through.
- Load funct3:
  - 000 LB, 001 LH, 010 LW, 011 LD: sign-extend.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
- Store funct3: 000 SB, 001 SH, 010 SW, 011 SD.
- Misaligned means the access crosses an 8-byte boundary, i.e. addr[2:0] + size > 8. A misaligned access:
  - issues no request;
  - fills the slot next cycle with misalign_o = 1, rdWriteEnable_o = 0, rdWriteData_o = 0.
- States:
  - IDLE: slot empty.
  - ACCESS: D-cache request outstanding.
  - HOLD: slot full.
- ready_o = (state == IDLE) || (state == HOLD && ready_i). A transfer is valid_i && ready_o.
- Transitions on a transfer, from IDLE or HOLD:
  - Pass-through or misaligned access: go to HOLD and register the result. Pass-through writes rdWriteData_o = aluResult_i.
  - Aligned LOAD/STORE: go to ACCESS and register address, data, mask and writeEnable.
- Transitions with no transfer:
  - HOLD with ready_i: go to IDLE.
  - ACCESS with dataOk_i: go to HOLD. A load captures the extended lane of readData_i. A store writes rdWriteEnable_o = 0.
- dataOk_i is ignored unless request_o = 1.
- Stores always write back with rdWriteEnable_o = 0, but still occupy the slot so pID ordering is preserved.

## Timing
- Reset value of every output is 0, except ready_o = 1. State resets to IDLE.
- Reset asserted during ACCESS abandons the access: request_o drops asynchronously and nothing is written back.
- Pass-through latency: valid_o rises the cycle after the transfer. Back-to-back transfers sustain one per cycle while ready_i = 1.
- Memory access:
  - request_o rises the cycle after the transfer.
  - request_o, addr_o, writeData_o, writeMask_o and writeEnable_o stay stable until the cycle in which dataOk_i = 1 (inclusive).
  - request_o falls the next cycle, and valid_o rises that same cycle.
  - dataOk_i may arrive as early as the first request cycle.
- ready_o = 0 throughout ACCESS.
- Slot outputs are held stable while valid_o = 1 && ready_i = 0.

## Configuration
- MEM_TESTPORT_EN defined:
  - Adds inputs instAddr_i[31:0] and inst_i[31:0] and outputs instAddr_o and inst_o.
  - These ports are registered alongside the slot with identical timing. Reset value is 0.
- MEM_TESTPORT_EN undefined: these ports and their registers do not exist. Functional behaviour is identical.

## Structure
- Shared package or header holds:
  - OPCODE_LOAD and OPCODE_STORE;
  - the funct3 size constants;
  - the state encoding (IDLE = 2'd0, ACCESS = 2'd1, HOLD = 2'd2).
- One combinational sub-module, mem_align_way0:
  - inputs funct3 and addr[2:0];
  - outputs misalign, writeMask, shifted writeData and extended load data.
- All sequencing stays in the top module.

## Test plan
- ADD pass-through, aluResult_i = 64'h1234, ready_i held 1, three back-to-back transfers -> valid_o on cycles 1–3, rdWriteData_o = 64'h1234, ready_o never drops.
- LB at addr 0x1003, readData_i = 64'h0000_0000_80FF_0000 (byte 3 = 0x80), dataOk_i 2 cycles after request -> rdWriteData_o = 64'hFFFF_FFFF_FFFF_FF80; LBU at the same address and data -> 64'h80.
- SW at addr 0x2004, storeData_i = 64'hDEADBEEF -> writeMask_o = 8'hF0, writeData_o = 64'hDEADBEEF_00000000, writeEnable_o = 1, slot rdWriteEnable_o = 0.
- LD at addr 0x3004 -> no request_o, valid_o next cycle with misalign_o = 1, rdWriteEnable_o = 0.
- Load completes while ready_i = 0 for 4 cycles -> slot outputs held stable, ready_o = 0, new valid_i not accepted until ready_i = 1.
- reset_n pulsed low during ACCESS -> request_o = 0 immediately, valid_o = 0, state IDLE, a later dataOk_i is ignored.
